// File: rtl/sram_pkg.sv
// Shared types and helpers for the CPU-side SRAM responder: FSM states,
// lane geometry and the byte-lane merge used by the write port.
package sram_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / LANE_W;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Replace the lanes of old_word selected by be with the matching lanes of new_word.
  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [LANES-1:0]  be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(LANES); i++) begin
      if (be[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_2r1w_bytewe.sv
// Word-organised storage with two synchronous read ports and one byte-enabled
// write port; reads return the pre-write word on a same-cycle collision.
module sram_2r1w_bytewe
  import sram_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_en,
  input  logic              a_zero,
  input  logic [AW-1:0]     a_idx,
  output logic [WORD_W-1:0] a_data,
  input  logic              b_en,
  input  logic              b_zero,
  input  logic [AW-1:0]     b_idx,
  output logic [WORD_W-1:0] b_data,
  input  logic [LANES-1:0]  w_be,
  input  logic [AW-1:0]     w_idx,
  input  logic [WORD_W-1:0] w_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents survive reset; only explicit writes change them.
  always_ff @(posedge clk) begin
    if (|w_be) mem[w_idx] <= lane_merge(mem[w_idx], w_data, w_be);
  end

  // zero forces a 0 result without touching the array (rejected address).
  always_ff @(posedge clk) begin
    if (!resetn)   a_data <= '0;
    else if (a_en) a_data <= a_zero ? '0 : mem[a_idx];
  end

  always_ff @(posedge clk) begin
    if (!resetn)   b_data <= '0;
    else if (b_en) b_data <= b_zero ? '0 : mem[b_idx];
  end

endmodule

// File: rtl/cpu_sram_responder.sv
// Memory-side responder for the single-cycle CPU: streams a program image in
// while holding the CPU in reset, then serves fetch and data ports.
module cpu_sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              cpu_resetn,
  input  logic              inst_sram_en,
  input  logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              addr_err,
  output logic [CNT_W-1:0]  store_cnt
);

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic              handshake;
  logic              run;
  logic [AW-1:0]     i_idx, d_idx;
  logic              i_oor, i_mis, d_oor, d_mis;
  logic              d_store;
  logic              bad_req;
  logic [LANES-1:0]  w_be;
  logic [AW-1:0]     w_idx;
  logic [WORD_W-1:0] w_data;

  assign handshake = load_valid & load_ready;
  assign run       = (state == S_RUN);

  assign i_idx = inst_sram_addr[AW+1:2];
  assign d_idx = data_sram_addr[AW+1:2];
  assign i_oor = |(inst_sram_addr >> (AW + 2));
  assign d_oor = |(data_sram_addr >> (AW + 2));
  assign i_mis = |inst_sram_addr[1:0];
  assign d_mis = |data_sram_addr[1:0];

  assign d_store = run & data_sram_en & (|data_sram_wen) & ~d_oor;
  assign bad_req = run & ((inst_sram_en & (i_oor | i_mis)) |
                          (data_sram_en & (d_oor | d_mis)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_LOAD;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Leave LOAD on the tagged last word or when the array is full; ptr saturates.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_LOAD: begin
        if (handshake) begin
          if (load_last || ptr == {AW{1'b1}}) state_nxt = S_RUN;
          if (ptr != {AW{1'b1}})              ptr_nxt   = ptr + AW'(1);
        end
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Single write port shared by the loader (LOAD) and CPU stores (RUN).
  always_comb begin
    w_be   = '0;
    w_idx  = '0;
    w_data = '0;
    if (resetn) begin
      if (state == S_LOAD && handshake) begin
        w_be   = {LANES{1'b1}};
        w_idx  = ptr;
        w_data = load_data;
      end else if (d_store) begin
        w_be   = data_sram_wen;
        w_idx  = d_idx;
        w_data = data_sram_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      load_ready <= 1'b0;
      cpu_resetn <= 1'b0;
      addr_err   <= 1'b0;
      store_cnt  <= '0;
    end else begin
      load_ready <= (state_nxt == S_LOAD);
      cpu_resetn <= run;
      if (bad_req) addr_err  <= 1'b1;
      if (d_store) store_cnt <= store_cnt + CNT_W'(1);
    end
  end

  sram_2r1w_bytewe #(.AW(AW)) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .a_en   (run & inst_sram_en),
    .a_zero (i_oor),
    .a_idx  (i_idx),
    .a_data (inst_sram_rdata),
    .b_en   (run & data_sram_en),
    .b_zero (d_oor),
    .b_idx  (d_idx),
    .b_data (data_sram_rdata),
    .w_be   (w_be),
    .w_idx  (w_idx),
    .w_data (w_data)
  );

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Self-checking bench for cpu_sram_responder: directed image-load and access
// scenarios followed by randomized CPU traffic against an array-based model.
module tb_cpu_sram_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              resetn;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic              cpu_resetn;
  logic              inst_sram_en;
  logic [31:0]       inst_sram_addr;
  logic [31:0]       inst_sram_rdata;
  logic              data_sram_en;
  logic [3:0]        data_sram_wen;
  logic [31:0]       data_sram_addr;
  logic [31:0]       data_sram_wdata;
  logic [31:0]       data_sram_rdata;
  logic              addr_err;
  logic [CNT_W-1:0]  store_cnt;

  always #5 clk = ~clk;

  cpu_sram_responder #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .load_last       (load_last),
    .cpu_resetn      (cpu_resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .addr_err        (addr_err),
    .store_cnt       (store_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: memory contents plus what each output should show.
  logic [31:0]      mem_m [DEPTH];
  logic [31:0]      exp_i, exp_d;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_err;
  int               ptr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_inst_rdata"}, inst_sram_rdata, exp_i);
    chk({tag, "_data_rdata"}, data_sram_rdata, exp_d);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'(exp_err));
    chk({tag, "_store_cnt"}, 32'(store_cnt), 32'(exp_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_en    = 1'b0;
    inst_sram_addr  = '0;
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
  endtask

  task automatic do_reset(input string tag);
    resetn     = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    idle();
    tick();
    exp_i   = '0;
    exp_d   = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
    ptr_m   = 0;
    check_outputs({tag, "_rst"});
    chk({tag, "_rst_load_ready"}, 32'(load_ready), 32'd0);
    chk({tag, "_rst_cpu_resetn"}, 32'(cpu_resetn), 32'd0);
    resetn = 1'b1;
    tick();
    chk({tag, "_post_rst_load_ready"}, 32'(load_ready), 32'd1);
  endtask

  task automatic load_word(input logic [31:0] w, input logic last);
    load_valid = 1'b1;
    load_data  = w;
    load_last  = last;
    chk("load_ready_before_hs", 32'(load_ready), 32'd1);
    tick();
    mem_m[ptr_m] = w;
    if (ptr_m != int'(DEPTH) - 1) ptr_m++;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("load_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check_outputs("load");
  endtask

  // One CPU cycle: model reads before applying the store, so fetch sees the old word.
  task automatic cpu_cycle(input logic ien, input logic [31:0] ia,
                           input logic den, input logic [3:0] w,
                           input logic [31:0] da, input logic [31:0] wd,
                           input string tag);
    logic [31:0] word;
    logic        oor;
    inst_sram_en    = ien;
    inst_sram_addr  = ia;
    data_sram_en    = den;
    data_sram_wen   = w;
    data_sram_addr  = da;
    data_sram_wdata = wd;
    if (ien) begin
      oor = (ia >> (AW + 2)) != 0;
      exp_i = oor ? 32'd0 : mem_m[ia[AW+1:2]];
      if (oor || ia[1:0] != 2'b00) exp_err = 1'b1;
    end
    if (den) begin
      oor = (da >> (AW + 2)) != 0;
      exp_d = oor ? 32'd0 : mem_m[da[AW+1:2]];
      if (oor || da[1:0] != 2'b00) exp_err = 1'b1;
      if (!oor && w != 4'b0000) begin
        word = mem_m[da[AW+1:2]];
        for (int i = 0; i < 4; i++)
          if (w[i]) word[i*8 +: 8] = wd[i*8 +: 8];
        mem_m[da[AW+1:2]] = word;
        exp_cnt++;
      end
    end
    tick();
    idle();
    check_outputs(tag);
    chk({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rd, rw;
    logic [3:0]  rwen;
    int          r;

    do_reset("init");

    // Image of four words; CPU traffic during LOAD must be ignored.
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h3;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'hF;
    data_sram_wdata = 32'hFFFF_FFFF;
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    load_word(32'h3333_3333, 1'b0);
    idle();
    load_word(32'h4444_4444, 1'b1);
    chk("after_last_load_ready", 32'(load_ready), 32'd0);
    tick();
    chk("release_cpu_resetn", 32'(cpu_resetn), 32'd1);
    check_outputs("release");

    cpu_cycle(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0, "fetch_8");
    chk("fetch_8_value", inst_sram_rdata, 32'h3333_3333);

    cpu_cycle(1'b0, 32'h0, 1'b1, 4'b0111, 32'h4, 32'hAABB_CCDD, "store_4");
    chk("store_4_prewrite", data_sram_rdata, 32'h2222_2222);
    cpu_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0, "read_4");
    chk("read_4_merged", data_sram_rdata, 32'h22BB_CCDD);
    chk("read_4_cnt", 32'(store_cnt), 32'd1);

    cpu_cycle(1'b1, 32'hC, 1'b1, 4'hF, 32'hC, 32'hDEAD_BEEF, "collide_c");
    chk("collide_c_old", inst_sram_rdata, 32'h4444_4444);
    cpu_cycle(1'b1, 32'hC, 1'b0, 4'h0, 32'h0, 32'h0, "refetch_c");
    chk("refetch_c_new", inst_sram_rdata, 32'hDEAD_BEEF);

    cpu_cycle(1'b1, 32'h6, 1'b0, 4'h0, 32'h0, 32'h0, "misaligned_6");
    chk("misaligned_6_err", 32'(addr_err), 32'd1);

    // Reset from RUN, abandon a partial image, then reload from index 0.
    do_reset("run_reset");
    load_word(32'hA0A0_A0A0, 1'b0);
    load_word(32'hA1A1_A1A1, 1'b0);
    do_reset("mid_load");
    load_word(32'h1111_1111, 1'b0);
    load_word(32'h2222_2222, 1'b0);
    load_word(32'h3333_3333, 1'b0);
    load_word(32'h4444_4444, 1'b1);
    tick();
    chk("reload_cpu_resetn", 32'(cpu_resetn), 32'd1);
    cpu_cycle(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "reload_fetch_0");
    chk("reload_fetch_0_value", inst_sram_rdata, 32'h1111_1111);

    cpu_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_1000, 32'h0, "oor_read");
    chk("oor_read_zero", data_sram_rdata, 32'h0);
    chk("oor_read_err", 32'(addr_err), 32'd1);
    cpu_cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, "oor_store");
    chk("oor_store_cnt", 32'(store_cnt), 32'd0);

    cpu_cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, "hold_read");
    for (int i = 0; i < 3; i++) cpu_cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, "hold_idle");
    chk("hold_value", data_sram_rdata, 32'h1111_1111);

    // Fill the whole array without load_last: the final slot ends loading.
    do_reset("full");
    for (int i = 0; i < int'(DEPTH); i++) load_word($urandom, 1'b0);
    chk("full_load_ready", 32'(load_ready), 32'd0);
    tick();
    chk("full_cpu_resetn", 32'(cpu_resetn), 32'd1);

    // Random concurrent traffic, mostly in-range; the narrow counter wraps here.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 15));
      ra = {20'h0, 2'b00, 10'($urandom), 2'b00};
      rd = {20'h0, 2'b00, 10'($urandom), 2'b00};
      if (r == 0) rd = rd | (32'h1 << $urandom_range(AW + 2, 31));
      if (r == 1) ra = ra | (32'h1 << $urandom_range(AW + 2, 31));
      if (r == 2) rd = rd | 32'($urandom_range(1, 3));
      if (r == 3) rd = ra;
      rw   = $urandom;
      rwen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cpu_cycle(1'($urandom), ra, 1'($urandom), rwen, rd, rw, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
